// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the 16-bit processor.
// It decodes the IR funct/opcode fields into datapath, register-file and memory controls.
// Fetch, load and store wait for mem_ready. Fetch can be stalled.
// Illegal opcodes enter a trap state. Each retired instruction produces a pulse and bumps a counter.
module mc_control_fsm #(
    parameter int unsigned FUNCT_W = 4,
    parameter int unsigned OPC_W   = 3,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    input  logic               stall,
    output logic               Branch,
    output logic               IoD,
    output logic               IRWrite,
    output logic               Mem2Reg,
    output logic               MemR,
    output logic               MemW,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic [1:0]         PCSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         BranchType,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               trap,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         current_state
);

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] S_FETCH    = 4'd0;
    localparam logic [ST_W-1:0] S_DECODE   = 4'd1;
    localparam logic [ST_W-1:0] S_RTYPE    = 4'd2;
    localparam logic [ST_W-1:0] S_RITYPE   = 4'd3;
    localparam logic [ST_W-1:0] S_RTYPEEND = 4'd4;
    localparam logic [ST_W-1:0] S_LW1      = 4'd5;
    localparam logic [ST_W-1:0] S_LW2      = 4'd6;
    localparam logic [ST_W-1:0] S_SW       = 4'd7;
    localparam logic [ST_W-1:0] S_JALR     = 4'd8;
    localparam logic [ST_W-1:0] S_BRANCH   = 4'd9;
    localparam logic [ST_W-1:0] S_BRANCH2  = 4'd10;
    localparam logic [ST_W-1:0] S_JAL      = 4'd11;
    localparam logic [ST_W-1:0] S_TRAP     = 4'd12;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] next_state;
    logic            fetch_go;

    // ALU operation selected by funct for register and immediate arithmetic.
    // Load/store funct codes reuse the add operation to form the address.
    function automatic logic [ALUOP_W-1:0] dec_alu(input logic [FUNCT_W-1:0] f);
        logic [ALUOP_W-1:0] r;
        if (f <= FUNCT_W'(8))
            r = ALUOP_W'(f[3:0]);
        else if (f == FUNCT_W'(9) || f == FUNCT_W'(10))
            r = '0;
        else if (f == FUNCT_W'(12))
            r = ALUOP_W'(12);
        else
            r = '1;
        return r;
    endfunction

    assign fetch_go      = mem_ready & ~stall;
    assign current_state = state;

    // State register. Reset forces FETCH asynchronously.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = fetch_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPC_W'(0))
                    next_state = S_RTYPE;
                else if (opcode == OPC_W'(1)) begin
                    if (funct == FUNCT_W'(11))
                        next_state = S_JALR;
                    else if (funct >= FUNCT_W'(12))
                        next_state = S_BRANCH;
                    else
                        next_state = S_RITYPE;
                end
                else if (opcode == OPC_W'(2))
                    next_state = S_RITYPE;
                else if (opcode == OPC_W'(3))
                    next_state = S_FETCH;
                else if (opcode == OPC_W'(4))
                    next_state = S_JAL;
                else
                    next_state = S_TRAP;
            end
            S_RTYPE:    next_state = S_RTYPEEND;
            S_RITYPE: begin
                if (funct == FUNCT_W'(9))
                    next_state = S_LW1;
                else if (funct == FUNCT_W'(10))
                    next_state = S_SW;
                else
                    next_state = S_RTYPEEND;
            end
            S_LW1:      next_state = mem_ready ? S_LW2 : S_LW1;
            S_SW:       next_state = mem_ready ? S_FETCH : S_SW;
            S_BRANCH:   next_state = S_BRANCH2;
            S_RTYPEEND: next_state = S_FETCH;
            S_LW2:      next_state = S_FETCH;
            S_JALR:     next_state = S_FETCH;
            S_JAL:      next_state = S_FETCH;
            S_BRANCH2:  next_state = S_FETCH;
            S_TRAP:     next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Datapath control decode. Defaults apply to unlisted and illegal states.
    always_comb begin
        Branch     = 1'b0;
        IoD        = 1'b0;
        IRWrite    = 1'b0;
        Mem2Reg    = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        PCSrc      = 2'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        BranchType = 2'd0;
        ALUOp      = '1;
        trap       = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                ALUOp   = '0;
                ALUSrcB = 2'd1;
                MemR    = ~stall;
                IRWrite = fetch_go;
                PCWrite = fetch_go;
            end
            S_RTYPE: begin
                ALUOp   = dec_alu(funct);
                ALUSrcA = 2'd2;
            end
            S_RITYPE: begin
                ALUOp   = dec_alu(funct);
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
            end
            S_RTYPEEND: RegWrite = 1'b1;
            S_LW1: begin
                IoD  = 1'b1;
                MemR = 1'b1;
            end
            S_LW2: begin
                Mem2Reg  = 1'b1;
                RegWrite = 1'b1;
            end
            S_SW: begin
                IoD  = 1'b1;
                MemW = 1'b1;
            end
            S_JALR: begin
                ALUOp    = ALUOP_W'(7);
                ALUSrcA  = 2'd3;
                ALUSrcB  = 2'd1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUOp      = ALUOP_W'(9);
                ALUSrcB    = 2'd2;
                Branch     = 1'b1;
                BranchType = funct[1:0];
            end
            S_BRANCH2: begin
                ALUOp      = ALUOP_W'(1);
                ALUSrcA    = 2'd2;
                Branch     = 1'b1;
                BranchType = funct[1:0];
                PCSrc      = 2'd1;
                PCWrite    = 1'b1;
            end
            S_JAL: begin
                ALUOp   = ALUOP_W'(7);
                ALUSrcA = 2'd3;
                ALUSrcB = 2'd1;
                PCWrite = 1'b1;
            end
            S_TRAP: begin
                PCSrc   = 2'd2;
                PCWrite = 1'b1;
                trap    = 1'b1;
            end
            default: ;
        endcase
        // An instruction retires when a legal non-fetch state returns to FETCH.
        instr_done = (state != S_FETCH) && (state <= S_TRAP) && (next_state == S_FETCH);
    end

    // Retired-instruction counter. It wraps at the counter width.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            instr_count <= '0;
        else if (instr_done)
            instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multi-cycle control unit for the 16-bit processor. It replaces the fixed 12-state controller with these additions:
- width-generic funct/opcode/ALUOp fields
- memory wait-state handshake on fetch, load and store
- fetch stall input
- illegal-opcode trap state
- retired-instruction pulse and counter

It sits between the instruction register (funct/opcode fields) and the datapath muxes, register file and memory.

Parameters:
FUNCT_W, 4, width of funct field (instr control bits [6:3] equivalent); must be >= 4
OPC_W, 3, width of opcode field; must be >= 3
ALUOP_W, 4, width of ALUOp output; must be >= 4
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
funct  in  FUNCT_W  IR function field, stable from DECODE to end of instruction
opcode  in  OPC_W  IR opcode field
mem_ready  in  1  memory completes current read/write this cycle
stall  in  1  hold in FETCH without issuing a memory read
Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCWrite, RegWrite  out  1 each  datapath controls
PCSrc  out  2  0=ALU result, 1=branch target, 2=trap vector
ALUSrcA, ALUSrcB, BranchType  out  2 each  datapath controls
ALUOp  out  ALUOP_W  ALU operation
trap  out  1  high in TRAP state
instr_done  out  1  pulse on cycle an instruction retires
instr_count  out  CNT_W  retired-instruction count
current_state  out  4  state encoding, for debug

Behaviour:
- State encoding (4-bit): FETCH=0, DECODE=1, RTYPE=2, RITYPE=3, RTYPEEND=4, LW1=5, LW2=6, SW=7, JALR=8, BRANCH=9, BRANCH2=10, JAL=11, TRAP=12. Codes 13-15 are illegal: they go to FETCH and drive default outputs.
- Reset (async, any cycle, mid-instruction included): state=FETCH, instr_count=0. Outputs immediately equal the FETCH decode.
- Output defaults in every state: ALUOp=all ones; every other output 0. States override as follows:
  - FETCH: ALUOp=0, SrcA=0, SrcB=1, MemR=~stall, IRWrite=PCWrite=mem_ready&~stall.
  - DECODE: defaults only.
  - RTYPE: ALUOp=dec(funct), SrcA=2, SrcB=0.
  - RITYPE: ALUOp=dec(funct), SrcA=2, SrcB=2.
  - RTYPEEND: RegWrite=1.
  - LW1: IoD=1, MemR=1.
  - LW2: Mem2Reg=1, RegWrite=1.
  - SW: IoD=1, MemW=1.
  - JALR: ALUOp=7, SrcA=3, SrcB=1, RegWrite=1.
  - BRANCH: ALUOp=9, SrcA=0, SrcB=2, Branch=1, BranchType=funct[1:0].
  - BRANCH2: ALUOp=1, SrcA=2, SrcB=0, Branch=1, BranchType=funct[1:0], PCSrc=1, PCWrite=1.
  - JAL: ALUOp=7, SrcA=3, SrcB=1, PCWrite=1.
  - TRAP: PCSrc=2, PCWrite=1, trap=1.
- dec(funct), zero-extended to ALUOP_W:
  - funct 0..8 -> funct.
  - funct 9, 10 -> 0.
  - funct 12 -> 12.
  - all other values -> all ones.
- Transitions:
  - FETCH -> DECODE when mem_ready&~stall; otherwise stay in FETCH.
  - DECODE, by opcode:
    - 0 -> RTYPE.
    - 1 -> JALR if funct=11; BRANCH if funct>=12; otherwise RITYPE.
    - 2 -> RITYPE.
    - 3 -> FETCH (L-type, no datapath action).
    - 4 -> JAL.
    - >=5 -> TRAP.
  - RTYPE -> RTYPEEND.
  - RITYPE -> LW1 if funct=9; SW if funct=10; otherwise RTYPEEND.
  - LW1 -> LW2 when mem_ready; otherwise stay in LW1.
  - SW -> FETCH when mem_ready; otherwise stay in SW.
  - BRANCH -> BRANCH2.
  - RTYPEEND, LW2, JALR, JAL, BRANCH2, TRAP -> FETCH.
- mem_ready is ignored outside FETCH/LW1/SW. stall is ignored outside FETCH; an instruction in flight always completes.
- In a waiting state all outputs hold their state values every cycle; there is no extra pulse on entry.
- instr_done (combinational) = 1 in any cycle where state!=FETCH and next_state==FETCH. Illegal states 13-15 excluded.
- instr_count increments on the CLK edge where instr_done=1 and wraps modulo 2^CNT_W.
- current_state is the registered state, zero latency.

Test Plan:
- mem_ready=1, opcode=0, funct=1: states 0,1,2,4,0. ALUOp=1 in RTYPE. RegWrite=1 only in RTYPEEND. instr_done high one cycle; instr_count 0->1.
- opcode=2, funct=9, mem_ready low for the first 2 cycles in LW1:
  - LW1 held 3 cycles with IoD=MemR=1, then LW2 with Mem2Reg=RegWrite=1.
  - 7 cycles total; count +1.
- opcode=1, funct=13: BRANCH then BRANCH2, both with BranchType=01. BRANCH2 has PCSrc=1 and PCWrite=1. Back in FETCH after 4 cycles.
- opcode=5: FETCH, DECODE, TRAP. In TRAP: trap=1, PCSrc=2, PCWrite=1; instr_done=1. Then FETCH.
- stall=1 for 3 cycles in FETCH: MemR=IRWrite=PCWrite=0 and state stays 0. Release stall with mem_ready=1: DECODE on the next edge.
- CNT_W=4, 16 back-to-back opcode=3 instrs: count wraps to 0. Assert Reset while in LW1: state=0 and count=0 before the next CLK edge.
